// File: rtl/cmac_usplus_0_pkt_mon_pkg.sv
// Shared types and constants for the CMAC RX packet monitor.
//   - pkt_mon_state_e : monitor state, encoded as the 4-bit code exported on rx_prestate
//   - sizing constants for beats, frame length and statistics counters
//   - sat_inc         : saturating increment for the 16-bit statistics counters
package cmac_usplus_0_pkt_mon_pkg;

    localparam int BEAT_BYTES    = 64;
    localparam int MAX_PKT_BYTES = 16000;
    localparam int LEN_W         = 14;
    localparam int CNT_W         = 16;
    localparam int BYTE_CNT_W    = 48;

    typedef enum logic [3:0] {
        S_WAIT_ALIGN = 4'd0,
        S_WAIT_SOP   = 4'd1,
        S_PKT        = 4'd2,
        S_DONE       = 4'd3
    } pkt_mon_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/cmac_usplus_0_axis_pkt_mon_if.sv
// AXI4-Stream RX beat bundle (no tready: the CMAC RX path cannot be stalled).
//   tvalid : beat valid
//   tdata  : 512-bit beat, byte k at [8k+7:8k]
//   tkeep  : byte enables, bit k qualifies byte k
//   tlast  : last beat of a frame
//   tuser  : frame (FCS) error, meaningful only with tlast
// Handshake: a beat transfers on every clock edge where tvalid=1; there is no
// ready, so the sink must accept every beat it sees.
interface cmac_usplus_0_axis_pkt_mon_if;
    import cmac_usplus_0_pkt_mon_pkg::*;

    logic                    tvalid;
    logic [BEAT_BYTES*8-1:0] tdata;
    logic [BEAT_BYTES-1:0]   tkeep;
    logic                    tlast;
    logic                    tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tuser);
    modport slave  (input  tvalid, tdata, tkeep, tlast, tuser);

endinterface

// File: rtl/cmac_usplus_0_tkeep_decode.sv
// Combinational tkeep decoder.
//   tkeep    in  64 : byte enables of one beat
//   byte_cnt out 7  : number of enabled bytes (0..64)
//   contig   out 1  : enables form a run starting at bit 0 (all-zero also counts as contiguous)
module cmac_usplus_0_tkeep_decode (
    input  logic [63:0] tkeep,
    output logic [6:0]  byte_cnt,
    output logic        contig
);

    always_comb begin
        byte_cnt = 7'd0;
        for (int k = 0; k < 64; k++) begin
            byte_cnt = byte_cnt + 7'(tkeep[k]);
        end
        // A run of ones from bit 0 has the form 2^n-1, so adding one clears every set bit.
        contig = ((tkeep & (tkeep + 64'd1)) == 64'd0);
    end

endmodule

// File: rtl/cmac_usplus_0_axis_pkt_mon.sv
// RX packet monitor for the CMAC 100G hardware test: checks every received frame
// for length/tkeep errors, payload pattern (byte at offset n == n[7:0]) and FCS
// error, and keeps saturating statistics.
// Optional feature macro: PKT_MON_PAYLOAD_CHK_EN builds the payload comparator;
// without it the payload mismatch flag is constant 0.
// Ports:
//   clk, reset (async, active-high), rx_aligned, restart (clears stats, rearms)
//   rx_axis        : AXI4-Stream slave beat bundle
//   *_cnt          : saturating frame/byte statistics
//   rx_prestate    : current state code
//   rx_*_led       : busy / done / aligned indicators
module cmac_usplus_0_axis_pkt_mon
    import cmac_usplus_0_pkt_mon_pkg::*;
#(
    parameter int PKT_NUM  = 1000,
    parameter int PKT_SIZE = 522
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           rx_aligned,
    input  logic                           restart,
    cmac_usplus_0_axis_pkt_mon_if.slave    rx_axis,
    output logic [CNT_W-1:0]               pkt_cnt,
    output logic [CNT_W-1:0]               good_cnt,
    output logic [CNT_W-1:0]               len_err_cnt,
    output logic [CNT_W-1:0]               data_err_cnt,
    output logic [CNT_W-1:0]               fcs_err_cnt,
    output logic [BYTE_CNT_W-1:0]          byte_cnt,
    output logic [3:0]                     rx_prestate,
    output logic                           rx_busy_led,
    output logic                           rx_done_led,
    output logic                           rx_aligned_led
);

    pkt_mon_state_e          state_q, state_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic                    len_err_q, len_err_d;
    logic                    data_err_q, data_err_d;
    logic [CNT_W-1:0]        pkt_cnt_q, pkt_cnt_d, good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0]        len_err_cnt_q, len_err_cnt_d, data_err_cnt_q, data_err_cnt_d;
    logic [CNT_W-1:0]        fcs_err_cnt_q, fcs_err_cnt_d;
    logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic                    busy_led_q, busy_led_d, done_led_q, done_led_d;
    logic                    aligned_led_q, aligned_led_d;

    logic [6:0]              keep_cnt;
    logic                    keep_contig;
    logic                    in_pkt;
    logic [LEN_W-1:0]        base_len, new_len;
    logic [LEN_W:0]          len_sum;
    logic                    base_len_err, base_data_err;
    logic                    beat_len_err, beat_data_err;
    logic                    frm_len_err, frm_data_err, last_pkt;
    logic [BYTE_CNT_W:0]     byte_sum;

    cmac_usplus_0_tkeep_decode u_tkeep_decode (
        .tkeep    (rx_axis.tkeep),
        .byte_cnt (keep_cnt),
        .contig   (keep_contig)
    );

`ifdef PKT_MON_PAYLOAD_CHK_EN
    // Beat index modulo 4 gives the frame-offset bits [7:6] of every byte in
    // the beat, since a beat is exactly 64 bytes.
    logic [1:0] beat_q, beat_d, base_beat;
    logic       frame_active;

    always_comb begin
        frame_active  = ((state_q == S_WAIT_SOP) || (state_q == S_PKT)) && rx_aligned;
        base_beat     = (state_q == S_PKT) ? beat_q : 2'd0;
        beat_d        = beat_q;
        if (restart) begin
            beat_d = 2'd0;
        end else if (frame_active && rx_axis.tvalid && !rx_axis.tlast) begin
            beat_d = base_beat + 2'd1;
        end
        beat_data_err = 1'b0;
        for (int k = 0; k < BEAT_BYTES; k++) begin
            if (rx_axis.tkeep[k] && (rx_axis.tdata[8*k +: 8] != {base_beat, 6'(k)})) begin
                beat_data_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) beat_q <= 2'd0;
        else       beat_q <= beat_d;
    end
`else
    assign beat_data_err = 1'b0;
`endif

    always_comb begin
        // A beat seen in S_WAIT_SOP starts a fresh frame, so it accumulates
        // from zero regardless of what the per-frame registers still hold.
        in_pkt        = (state_q == S_PKT);
        base_len      = in_pkt ? len_q : '0;
        base_len_err  = in_pkt & len_err_q;
        base_data_err = in_pkt & data_err_q;
        len_sum       = {1'b0, base_len} +
                        (rx_axis.tlast ? (LEN_W+1)'(keep_cnt) : (LEN_W+1)'(BEAT_BYTES));
        new_len       = len_sum[LEN_W] ? {LEN_W{1'b1}} : len_sum[LEN_W-1:0];
        beat_len_err  = rx_axis.tlast ? (!keep_contig || (keep_cnt == 7'd0))
                                      : (rx_axis.tkeep != {BEAT_BYTES{1'b1}});
        frm_len_err   = base_len_err | beat_len_err | (new_len != LEN_W'(PKT_SIZE));
        frm_data_err  = base_data_err | beat_data_err;
        last_pkt      = (({1'b0, pkt_cnt_q} + 17'd1) == 17'(PKT_NUM));
        byte_sum      = {1'b0, byte_cnt_q} + (BYTE_CNT_W+1)'(new_len);

        state_d        = state_q;
        len_d          = len_q;
        len_err_d      = len_err_q;
        data_err_d     = data_err_q;
        pkt_cnt_d      = pkt_cnt_q;
        good_cnt_d     = good_cnt_q;
        len_err_cnt_d  = len_err_cnt_q;
        data_err_cnt_d = data_err_cnt_q;
        fcs_err_cnt_d  = fcs_err_cnt_q;
        byte_cnt_d     = byte_cnt_q;

        if (restart) begin
            state_d        = S_WAIT_ALIGN;
            len_d          = '0;
            len_err_d      = 1'b0;
            data_err_d     = 1'b0;
            pkt_cnt_d      = '0;
            good_cnt_d     = '0;
            len_err_cnt_d  = '0;
            data_err_cnt_d = '0;
            fcs_err_cnt_d  = '0;
            byte_cnt_d     = '0;
        end else begin
            case (state_q)
                S_WAIT_ALIGN: if (rx_aligned) state_d = S_WAIT_SOP;
                S_WAIT_SOP, S_PKT: begin
                    if (!rx_aligned) begin
                        // Partial frame is dropped; its flags are ignored on the next SOP.
                        state_d = S_WAIT_ALIGN;
                    end else if (rx_axis.tvalid) begin
                        if (rx_axis.tlast) begin
                            pkt_cnt_d      = sat_inc(pkt_cnt_q, 1'b1);
                            good_cnt_d     = sat_inc(good_cnt_q,
                                                     !frm_len_err && !frm_data_err && !rx_axis.tuser);
                            len_err_cnt_d  = sat_inc(len_err_cnt_q, frm_len_err);
                            data_err_cnt_d = sat_inc(data_err_cnt_q, frm_data_err);
                            fcs_err_cnt_d  = sat_inc(fcs_err_cnt_q, rx_axis.tuser);
                            byte_cnt_d     = byte_sum[BYTE_CNT_W] ? {BYTE_CNT_W{1'b1}}
                                                                  : byte_sum[BYTE_CNT_W-1:0];
                            state_d        = last_pkt ? S_DONE : S_WAIT_SOP;
                        end else begin
                            len_d      = new_len;
                            len_err_d  = base_len_err | beat_len_err;
                            data_err_d = frm_data_err;
                            state_d    = S_PKT;
                        end
                    end
                end
                default: ;
            endcase
        end

        busy_led_d    = (state_d == S_WAIT_SOP) || (state_d == S_PKT);
        done_led_d    = (state_d == S_DONE);
        aligned_led_d = rx_aligned;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_WAIT_ALIGN;
            len_q          <= '0;
            len_err_q      <= 1'b0;
            data_err_q     <= 1'b0;
            pkt_cnt_q      <= '0;
            good_cnt_q     <= '0;
            len_err_cnt_q  <= '0;
            data_err_cnt_q <= '0;
            fcs_err_cnt_q  <= '0;
            byte_cnt_q     <= '0;
            busy_led_q     <= 1'b0;
            done_led_q     <= 1'b0;
            aligned_led_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            len_err_q      <= len_err_d;
            data_err_q     <= data_err_d;
            pkt_cnt_q      <= pkt_cnt_d;
            good_cnt_q     <= good_cnt_d;
            len_err_cnt_q  <= len_err_cnt_d;
            data_err_cnt_q <= data_err_cnt_d;
            fcs_err_cnt_q  <= fcs_err_cnt_d;
            byte_cnt_q     <= byte_cnt_d;
            busy_led_q     <= busy_led_d;
            done_led_q     <= done_led_d;
            aligned_led_q  <= aligned_led_d;
        end
    end

    assign pkt_cnt        = pkt_cnt_q;
    assign good_cnt       = good_cnt_q;
    assign len_err_cnt    = len_err_cnt_q;
    assign data_err_cnt   = data_err_cnt_q;
    assign fcs_err_cnt    = fcs_err_cnt_q;
    assign byte_cnt       = byte_cnt_q;
    assign rx_prestate    = state_q;
    assign rx_busy_led    = busy_led_q;
    assign rx_done_led    = done_led_q;
    assign rx_aligned_led = aligned_led_q;

endmodule
